// File: rtl/demux1to8_pkg.sv
// Shared definitions for the 8-slot bit-select path (transmit selector and
// receive deserialiser).
package demux1to8_pkg;

  localparam int unsigned N_SLOTS = 8;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic {HUNT, ASSEMBLE} state_t;

  // Bit position of a slot within the byte: slot k -> bit k (LSB first) or bit 7-k.
  function automatic logic [SEL_W-1:0] slot_to_bit(input logic [SEL_W-1:0] slot,
                                                   input bit               lsb_first);
    return lsb_first ? slot : (SEL_W'(N_SLOTS - 1) - slot);
  endfunction

endpackage

// File: rtl/demux1to8_slot_wr.sv
// Combinational 1-to-8 slot decoder: writes din into the bit of the assembly
// register selected by idx when enabled.
module demux1to8_slot_wr
  import demux1to8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [SEL_W-1:0]   i_idx,
  input  logic               i_din,
  input  logic               i_we,
  input  logic [N_SLOTS-1:0] i_asm,
  output logic [N_SLOTS-1:0] o_asm_next
);

  always_comb begin
    o_asm_next = i_asm;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      if (i_we && (slot_to_bit(i_idx, LSB_FIRST) == SEL_W'(k))) begin
        o_asm_next[k] = i_din;
      end
    end
  end

endmodule

// File: rtl/demux1to8_deser.sv
// Serial-to-byte deserialiser: slot counter, HUNT/ASSEMBLE framing FSM,
// one-word valid/ready output buffer and sticky overrun flag.
module demux1to8_deser
  import demux1to8_pkg::*;
#(
  parameter bit LSB_FIRST    = 1'b1,
  parameter bit REQUIRE_SYNC = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               sync,
  input  logic               q_ready,
  input  logic               clear_ovr,
  output logic [N_SLOTS-1:0] q,
  output logic               q_valid,
  output logic [SEL_W-1:0]   sel_out,
  output logic               hunting,
  output logic               overrun
);

  localparam state_t RST_STATE = REQUIRE_SYNC ? HUNT : ASSEMBLE;

  state_t             r_state;
  state_t             w_state_next;
  logic [SEL_W-1:0]   r_idx;
  logic [N_SLOTS-1:0] r_asm;
  logic [N_SLOTS-1:0] r_q;
  logic               r_q_valid;
  logic               r_ovr;

  logic               w_accept;
  logic [SEL_W-1:0]   w_wr_idx;
  logic [N_SLOTS-1:0] w_asm_next;
  logic               w_complete;
  logic               w_can_load;

  // A sync always restarts at slot 0, so in HUNT only synced bits are accepted.
  assign w_accept   = din_valid && ((r_state == ASSEMBLE) || sync);
  assign w_wr_idx   = sync ? '0 : r_idx;
  assign w_complete = w_accept && (w_wr_idx == SEL_W'(N_SLOTS - 1));
  assign w_can_load = !r_q_valid || q_ready;

  demux1to8_slot_wr #(
    .LSB_FIRST (LSB_FIRST)
  ) u_slot_wr (
    .i_idx      (w_wr_idx),
    .i_din      (din),
    .i_we       (w_accept),
    .i_asm      (r_asm),
    .o_asm_next (w_asm_next)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = ASSEMBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_asm     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx <= w_wr_idx + 1'b1;
        r_asm <= w_asm_next;
      end

      // Completion takes priority over a plain consume so a word arriving in
      // the same cycle as the buffer drains is loaded without a bubble.
      if (w_complete && w_can_load) begin
        r_q       <= w_asm_next;
        r_q_valid <= 1'b1;
      end else if (r_q_valid && q_ready) begin
        r_q_valid <= 1'b0;
      end

      if (w_complete && !w_can_load) begin
        r_ovr <= 1'b1;
      end else if (clear_ovr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign sel_out = r_idx;
  assign hunting = (r_state == HUNT);
  assign overrun = r_ovr;

endmodule

// File: tb/tb_demux1to8_deser.sv
// Directed bench for demux1to8_deser: an LSB-first instance and an MSB-first
// instance driven by the same serial stream.
module tb_demux1to8_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic       q_ready = 1'b1;
  logic       clear_ovr = 1'b0;

  logic [7:0] q,  q2;
  logic       q_valid, q_valid2;
  logic [2:0] sel_out, sel_out2;
  logic       hunting, hunting2;
  logic       overrun, overrun2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux1to8_deser #(.LSB_FIRST(1'b1), .REQUIRE_SYNC(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .q_ready(q_ready), .clear_ovr(clear_ovr), .q(q), .q_valid(q_valid),
    .sel_out(sel_out), .hunting(hunting), .overrun(overrun)
  );

  demux1to8_deser #(.LSB_FIRST(1'b0), .REQUIRE_SYNC(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .q_ready(q_ready), .clear_ovr(clear_ovr), .q(q2), .q_valid(q_valid2),
    .sel_out(sel_out2), .hunting(hunting2), .overrun(overrun2)
  );

  task automatic send_bit(input logic b, input logic s, input logic clr);
    din = b; sync = s; din_valid = 1'b1; clear_ovr = clr;
    @(posedge clk); #1;
    din_valid = 1'b0; sync = 1'b0; clear_ovr = 1'b0; din = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Slot k carries w[k]; q_ready / clear_ovr for the final bit are given explicitly.
  task automatic send_word(input logic [7:0] w, input logic s,
                           input logic last_rdy, input logic last_clr);
    logic prev_rdy;
    prev_rdy = q_ready;
    for (int k = 0; k < 7; k++) send_bit(w[k], (k == 0) ? s : 1'b0, 1'b0);
    q_ready = last_rdy;
    send_bit(w[7], 1'b0, last_clr);
    q_ready = prev_rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    total++; if (q !== 8'h00)   begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_qv got=%b exp=0", q_valid); end
    total++; if (sel_out !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel_out); end
    total++; if (hunting !== 1'b1) begin bad++; $display("FAIL reset_hunt got=%b exp=1", hunting); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
  endtask

  task automatic test_basic();
    logic [7:0] bits;
    bits = 8'b1010_0101; // bits[k] is the k-th bit on the wire: 1,0,1,0,0,1,0,1
    q_ready = 1'b1;
    for (int k = 0; k < 7; k++) send_bit(bits[k], k == 0, 1'b0);
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL basic_qv_early got=%b exp=0", q_valid); end
    total++; if (sel_out !== 3'd7) begin bad++; $display("FAIL basic_sel7 got=%0d exp=7", sel_out); end
    send_bit(bits[7], 1'b0, 1'b0);
    total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL basic_qv got=%b exp=1", q_valid); end
    total++; if (q !== 8'hA5)      begin bad++; $display("FAIL basic_q got=%h exp=a5", q); end
    total++; if (sel_out !== 3'd0) begin bad++; $display("FAIL basic_sel got=%0d exp=0", sel_out); end
    total++; if (q2 !== 8'hA5)     begin bad++; $display("FAIL basic_q_msb got=%h exp=a5", q2); end
    idle(1);
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL basic_consume got=%b exp=0", q_valid); end
    total++; if (q !== 8'hA5)      begin bad++; $display("FAIL basic_qhold got=%h exp=a5", q); end
  endtask

  task automatic test_hunt();
    logic [4:0] junk;
    junk = 5'b10111;
    do_reset();
    for (int k = 0; k < 5; k++) send_bit(junk[k], 1'b0, 1'b0);
    total++; if (hunting !== 1'b1) begin bad++; $display("FAIL hunt_stay got=%b exp=1", hunting); end
    total++; if (sel_out !== 3'd0) begin bad++; $display("FAIL hunt_sel got=%0d exp=0", sel_out); end
    sync = 1'b1; idle(1); sync = 1'b0;
    total++; if (hunting !== 1'b1) begin bad++; $display("FAIL hunt_sync_novalid got=%b exp=1", hunting); end
    send_bit(1'b0, 1'b1, 1'b0);
    total++; if (hunting !== 1'b0) begin bad++; $display("FAIL hunt_exit got=%b exp=0", hunting); end
    total++; if (sel_out !== 3'd1) begin bad++; $display("FAIL hunt_sel1 got=%0d exp=1", sel_out); end
    do_reset();
    send_word(8'h3C, 1'b1, 1'b1, 1'b0);
    total++; if (q !== 8'h3C || q_valid !== 1'b1)
      begin bad++; $display("FAIL hunt_word got=%h/%b exp=3c/1", q, q_valid); end
    idle(1);
  endtask

  task automatic test_overrun();
    q_ready = 1'b0;
    send_word(8'h11, 1'b1, 1'b0, 1'b0);
    total++; if (q !== 8'h11 || q_valid !== 1'b1)
      begin bad++; $display("FAIL ovr_first got=%h/%b exp=11/1", q, q_valid); end
    for (int k = 0; k < 7; k++) send_bit(k == 1 || k == 5, 1'b0, 1'b0);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b exp=0", overrun); end
    send_bit(1'b0, 1'b0, 1'b0);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    total++; if (q !== 8'h11)      begin bad++; $display("FAIL ovr_qhold got=%h exp=11", q); end
    total++; if (sel_out !== 3'd0) begin bad++; $display("FAIL ovr_wrap got=%0d exp=0", sel_out); end
    clear_ovr = 1'b1; idle(1); clear_ovr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    send_word(8'h5A, 1'b0, 1'b0, 1'b1);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_drop_wins got=%b exp=1", overrun); end
    clear_ovr = 1'b1; idle(1); clear_ovr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear2 got=%b exp=0", overrun); end
  endtask

  task automatic test_back_to_back();
    q_ready = 1'b1; idle(1); q_ready = 1'b0;
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", q_valid); end
    send_word(8'h66, 1'b1, 1'b0, 1'b0);
    total++; if (q !== 8'h66) begin bad++; $display("FAIL b2b_first got=%h exp=66", q); end
    send_word(8'h77, 1'b0, 1'b1, 1'b0);
    total++; if (q !== 8'h77)      begin bad++; $display("FAIL b2b_q got=%h exp=77", q); end
    total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL b2b_qv got=%b exp=1", q_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b exp=0", overrun); end
  endtask

  task automatic test_resync();
    q_ready = 1'b1; idle(1);
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0, 1'b0);
    total++; if (sel_out !== 3'd4) begin bad++; $display("FAIL resync_partial got=%0d exp=4", sel_out); end
    send_word(8'hF0, 1'b1, 1'b1, 1'b0);
    total++; if (q !== 8'hF0)      begin bad++; $display("FAIL resync_q got=%h exp=f0", q); end
    total++; if (q2 !== 8'h0F)     begin bad++; $display("FAIL resync_q_msb got=%h exp=0f", q2); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL resync_ovr got=%b exp=0", overrun); end
  endtask

  task automatic test_reset_midword();
    q_ready = 1'b0;
    for (int k = 0; k < 6; k++) send_bit(1'b1, 1'b0, 1'b0);
    total++; if (q_valid !== 1'b1 || sel_out !== 3'd6)
      begin bad++; $display("FAIL mid_pre got=%b/%0d exp=1/6", q_valid, sel_out); end
    do_reset();
    total++; if (q !== 8'h00)      begin bad++; $display("FAIL mid_q got=%h exp=00", q); end
    total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL mid_qv got=%b exp=0", q_valid); end
    total++; if (sel_out !== 3'd0) begin bad++; $display("FAIL mid_sel got=%0d exp=0", sel_out); end
    total++; if (hunting !== 1'b1) begin bad++; $display("FAIL mid_hunt got=%b exp=1", hunting); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_hunt();
    test_overrun();
    test_back_to_back();
    test_resync();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
